// File: rtl/mem_store_align.sv
// MEM-stage data access unit: packs stores into byte lanes with strobes, extends loads,
// and runs the sram-like req/addr_ok/data_ok handshake with misalignment trapping.
module mem_store_align #(
    parameter int ADDR_W      = 32,
    parameter int CHECK_ALIGN = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              flush,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    output logic [3:0]        data_wstrb,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_adel,
    output logic              resp_ades
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic uns,
                                                input logic [1:0] a, input logic [31:0] rd);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = rd[{a, 3'b000} +: 8];
        h = rd[{a[1], 4'b0000} +: 16];
        case (size)
            2'b00:   return uns ? {24'b0, b} : 32'(b);
            2'b01:   return uns ? {16'b0, h} : 32'(h);
            default: return rd;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic              cancel_q, cancel_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              data_req_q, data_req_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              adel_q, adel_d;
    logic              ades_q, ades_d;

    logic              misaligned;
    logic              done;
    logic [ADDR_W-1:0] addr_fix;

    always_comb begin
        state_d      = state_q;
        cancel_d     = cancel_q;
        wr_d         = wr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        data_req_d   = data_req_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        adel_d       = 1'b0;
        ades_d       = 1'b0;
        done         = 1'b0;

        misaligned = 1'b0;
        addr_fix   = req_addr;
        if (CHECK_ALIGN != 0) begin
            misaligned = (req_size == 2'b01 && req_addr[0]) ||
                         (req_size[1] && req_addr[1:0] != 2'b00);
        end else if (req_size == 2'b01) begin
            addr_fix[0] = 1'b0;
        end else if (req_size[1]) begin
            addr_fix[1:0] = 2'b00;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    wr_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = addr_fix;
                    wdata_d = store_lanes(req_size, req_wdata);
                    wstrb_d = req_we ? store_strb(req_size, addr_fix[1:0]) : 4'b0000;
                    if (misaligned) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        adel_d       = !req_we;
                        ades_d       = req_we;
                    end else begin
                        state_d    = S_REQ;
                        data_req_d = 1'b1;
                    end
                end
            end
            // The bus request cannot be withdrawn once raised; a flush only marks it cancelled.
            S_REQ: begin
                cancel_d = cancel_q | flush;
                if (data_addr_ok) begin
                    data_req_d = 1'b0;
                    state_d    = S_WAIT;
                    done       = data_data_ok;
                end
            end
            S_WAIT: begin
                cancel_d = cancel_q | flush;
                done     = data_data_ok;
            end
            default: state_d = S_IDLE;
        endcase

        if (done) begin
            cancel_d = 1'b0;
            if (cancel_q || flush) begin
                state_d = S_IDLE;
            end else begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = wr_q ? 32'h0 : load_extend(size_q, uns_q, addr_q[1:0], data_rdata);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cancel_q     <= 1'b0;
            wr_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            data_req_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            adel_q       <= 1'b0;
            ades_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cancel_q     <= cancel_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            data_req_q   <= data_req_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            adel_q       <= adel_d;
            ades_q       <= ades_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign data_req   = data_req_q;
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign data_wstrb = wstrb_q;
    // A late flush kills the completion pulse in its only cycle.
    assign resp_valid = resp_valid_q & !flush;
    assign resp_rdata = flush ? 32'h0 : resp_rdata_q;
    assign resp_adel  = adel_q & !flush;
    assign resp_ades  = ades_q & !flush;

endmodule

// File: tb/tb_mem_store_align.sv
// Directed bench for mem_store_align: stimulus pushes expected responses into a queue,
// a monitor pops and compares whenever resp_valid is seen.
`timescale 1ns/1ps
module tb_mem_store_align;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        flush = 1'b0;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_adel, resp_ades;

    typedef struct {
        logic [31:0] rdata;
        logic        adel;
        logic        ades;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    mem_store_align #(.ADDR_W(32), .CHECK_ALIGN(1)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .flush(flush),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_adel(resp_adel), .resp_ades(resp_ades)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_resp(input logic [31:0] rd, input logic adel, input logic ades);
        exp_t e;
        e.rdata = rd;
        e.adel  = adel;
        e.ades  = ades;
        exp_q.push_back(e);
    endtask

    // Presents one request for a single cycle; returns in the cycle after acceptance.
    task automatic access(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        tick();
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        tick();
        req_valid = 1'b0;
    endtask

    // Slave side: addr_ok after addr_delay request cycles, data_ok in the first WAIT cycle.
    task automatic run_bus(input int addr_delay, input logic [31:0] addr, input logic [31:0] rd);
        for (int i = 0; i < addr_delay; i++) begin
            chk("req_held", {31'b0, data_req}, 32'd1);
            chk("addr_held", data_addr, addr);
            tick();
        end
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata = rd;
        tick();
        data_data_ok = 1'b0;
    endtask

    // Monitor: samples after the stimulus has settled in each cycle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", {31'b0, resp_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_adel", {31'b0, resp_adel}, {31'b0, e.adel});
                    chk("resp_ades", {31'b0, resp_ades}, {31'b0, e.ades});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_data_req", {31'b0, data_req}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_wstrb", {28'b0, data_wstrb}, 32'd0);
        chk("rst_data_addr", data_addr, 32'd0);
        resetn = 1'b1;
        tick();
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

        // sb 0xA5 to byte 3
        expect_resp(32'h0, 1'b0, 1'b0);
        access(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5);
        chk("sb_req", {31'b0, data_req}, 32'd1);
        chk("sb_wdata", data_wdata, 32'hA5A5_A5A5);
        chk("sb_wstrb", {28'b0, data_wstrb}, 32'h8);
        chk("sb_wr", {31'b0, data_wr}, 32'd1);
        chk("sb_ready_busy", {31'b0, req_ready}, 32'd0);
        run_bus(0, 32'h0000_1003, 32'h0);
        chk("sb_latency", {31'b0, resp_valid}, 32'd1);
        tick();
        chk("sb_one_pulse", {31'b0, resp_valid}, 32'd0);

        // lb / lbu from byte 2
        expect_resp(32'hFFFF_FF80, 1'b0, 1'b0);
        access(1'b0, 2'b00, 1'b0, 32'h0000_2002, 32'h0);
        chk("lb_wstrb", {28'b0, data_wstrb}, 32'h0);
        chk("lb_wr", {31'b0, data_wr}, 32'd0);
        run_bus(0, 32'h0000_2002, 32'h1280_3456);
        expect_resp(32'h0000_0080, 1'b0, 1'b0);
        access(1'b0, 2'b00, 1'b1, 32'h0000_2002, 32'h0);
        run_bus(0, 32'h0000_2002, 32'h1280_3456);

        // sh to upper half, lh/lhu upper half, lh lower half
        expect_resp(32'h0, 1'b0, 1'b0);
        access(1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h1234_ABCD);
        chk("sh_wdata", data_wdata, 32'hABCD_ABCD);
        chk("sh_wstrb", {28'b0, data_wstrb}, 32'hC);
        chk("sh_size", {30'b0, data_size}, 32'd1);
        run_bus(0, 32'h0000_3002, 32'h0);
        expect_resp(32'hFFFF_8001, 1'b0, 1'b0);
        access(1'b0, 2'b01, 1'b0, 32'h0000_3002, 32'h0);
        run_bus(0, 32'h0000_3002, 32'h8001_7FFF);
        expect_resp(32'h0000_8001, 1'b0, 1'b0);
        access(1'b0, 2'b01, 1'b1, 32'h0000_3002, 32'h0);
        run_bus(0, 32'h0000_3002, 32'h8001_7FFF);
        expect_resp(32'h0000_7FFF, 1'b0, 1'b0);
        access(1'b0, 2'b01, 1'b0, 32'h0000_3000, 32'h0);
        run_bus(0, 32'h0000_3000, 32'h8001_7FFF);

        // sw full word
        expect_resp(32'h0, 1'b0, 1'b0);
        access(1'b1, 2'b10, 1'b0, 32'h0000_3100, 32'h0BAD_F00D);
        chk("sw_wdata", data_wdata, 32'h0BAD_F00D);
        chk("sw_wstrb", {28'b0, data_wstrb}, 32'hF);
        run_bus(0, 32'h0000_3100, 32'h0);

        // misaligned lh and sw trap without a bus cycle
        expect_resp(32'h0, 1'b1, 1'b0);
        access(1'b0, 2'b01, 1'b0, 32'h0000_4001, 32'h0);
        chk("lh_mis_noreq", {31'b0, data_req}, 32'd0);
        chk("lh_mis_latency", {31'b0, resp_valid}, 32'd1);
        tick();
        chk("lh_mis_noreq2", {31'b0, data_req}, 32'd0);
        expect_resp(32'h0, 1'b0, 1'b1);
        access(1'b1, 2'b10, 1'b0, 32'h0000_4002, 32'h1111_2222);
        chk("sw_mis_noreq", {31'b0, data_req}, 32'd0);
        tick();

        // lw with addr_ok held off for four cycles
        expect_resp(32'hDEAD_BEEF, 1'b0, 1'b0);
        access(1'b0, 2'b10, 1'b0, 32'h0000_5004, 32'h0);
        run_bus(4, 32'h0000_5004, 32'hDEAD_BEEF);
        chk("lw_slow_resp", {31'b0, resp_valid}, 32'd1);

        // addr_ok and data_ok together in REQ
        expect_resp(32'hCAFE_F00D, 1'b0, 1'b0);
        access(1'b0, 2'b11, 1'b0, 32'h0000_5008, 32'h0);
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        chk("fast_resp", {31'b0, resp_valid}, 32'd1);
        tick();

        // flush during WAIT: data_ok completes silently
        access(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA;
        tick();
        data_data_ok = 1'b0;
        chk("flush_wait_ready", {31'b0, req_ready}, 32'd1);
        chk("flush_wait_noresp", {31'b0, resp_valid}, 32'd0);

        // flush during REQ: request stays up until addr_ok, then no response
        access(1'b0, 2'b10, 1'b0, 32'h0000_6004, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_req_held", {31'b0, data_req}, 32'd1);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        chk("flush_req_ready", {31'b0, req_ready}, 32'd1);

        // flush in RESP drops the pulse
        access(1'b0, 2'b10, 1'b0, 32'h0000_6008, 32'h0);
        run_bus(0, 32'h0000_6008, 32'h1234_5678);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // flush in IDLE blocks acceptance
        tick();
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_7000; flush = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_noreq", {31'b0, data_req}, 32'd0);
        chk("flush_idle_ready", {31'b0, req_ready}, 32'd1);

        // reset in the middle of REQ
        access(1'b0, 2'b10, 1'b0, 32'h0000_7004, 32'h0);
        chk("mid_req_up", {31'b0, data_req}, 32'd1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("mid_rst_req", {31'b0, data_req}, 32'd0);
        chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("mid_rst_resp", {31'b0, resp_valid}, 32'd0);

        tick(); tick(); tick();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
